// File: rtl/tlb_lookup_stage.sv
// tlb_lookup_stage
//   Registered lookup stage behind the TLB CAM. For each of NPORT ports it
//   turns a CAM hit vector plus a virtual address into a physical address,
//   MAT, LoongArch TLB exception code and a multi-hit flag. Each port keeps a
//   saturating miss counter.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   all_{pfn,mat,plv,d,v}0   even-page fields of every entry (packed, entry 0 in LSBs)
//   all_{pfn,mat,plv,d,v}1   odd-page fields of every entry
//   all_ps                   page size per entry (21 = 2 MB, anything else = 4 KB)
//   cur_plv                  current privilege level
//   in_valid/in_ready        per-port request handshake
//   found, va, acc_type      per-port CAM hit vector, virtual address, access type
//   out_valid/out_ready      per-port result handshake
//   out_pa, out_mat, out_exc, out_multihit   per-port registered result
//   flush                    drop all results and any capture in this cycle
//   cnt_clr                  clear all miss counters
//   miss_cnt                 per-port saturating miss count
//
// Handshake (per port, ports fully independent): a request is taken when
// in_valid && in_ready, and in_ready = !out_valid || out_ready. The result
// is presented one cycle later and held stable while out_valid && !out_ready.
// With no capture, out_ready=1 retires the held result.
module tlb_lookup_stage #(
  parameter int TLBNUM = 16,
  parameter int NPORT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TLBNUM*20-1:0]    all_pfn0,
  input  logic [TLBNUM*2-1:0]     all_mat0,
  input  logic [TLBNUM*2-1:0]     all_plv0,
  input  logic [TLBNUM-1:0]       all_d0,
  input  logic [TLBNUM-1:0]       all_v0,
  input  logic [TLBNUM*20-1:0]    all_pfn1,
  input  logic [TLBNUM*2-1:0]     all_mat1,
  input  logic [TLBNUM*2-1:0]     all_plv1,
  input  logic [TLBNUM-1:0]       all_d1,
  input  logic [TLBNUM-1:0]       all_v1,
  input  logic [TLBNUM*6-1:0]     all_ps,
  input  logic [1:0]              cur_plv,
  input  logic [NPORT-1:0]        in_valid,
  output logic [NPORT-1:0]        in_ready,
  input  logic [NPORT*TLBNUM-1:0] found,
  input  logic [NPORT*32-1:0]     va,
  input  logic [NPORT*2-1:0]      acc_type,
  output logic [NPORT-1:0]        out_valid,
  input  logic [NPORT-1:0]        out_ready,
  output logic [NPORT*32-1:0]     out_pa,
  output logic [NPORT*2-1:0]      out_mat,
  output logic [NPORT*3-1:0]      out_exc,
  output logic [NPORT-1:0]        out_multihit,
  input  logic                    flush,
  input  logic                    cnt_clr,
  output logic [NPORT*CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_TLBR = 3'd1;
  localparam logic [2:0] EXC_PIF  = 3'd2;
  localparam logic [2:0] EXC_PIL  = 3'd3;
  localparam logic [2:0] EXC_PIS  = 3'd4;
  localparam logic [2:0] EXC_PME  = 3'd5;
  localparam logic [2:0] EXC_PPI  = 3'd6;

  localparam logic [1:0] ACC_FETCH = 2'b00;
  localparam logic [1:0] ACC_STORE = 2'b10;

  localparam logic [TLBNUM-1:0] ONE_T = TLBNUM'(1);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [TLBNUM-1:0] hit_vec;
    logic [31:0]       va_p;
    logic [1:0]        acc_p;
    logic              hit;
    logic              multi;
    logic [IDX_W-1:0]  idx;
    logic              big;
    logic              odd;
    logic [19:0]       pfn;
    logic [1:0]        mat;
    logic [1:0]        plv;
    logic              d;
    logic              v;
    logic [31:0]       pa_d;
    logic [1:0]        mat_d;
    logic [2:0]        exc_d;
    logic              capture;
    logic              valid_q, valid_d;
    logic [31:0]       pa_q;
    logic [1:0]        mat_q;
    logic [2:0]        exc_q;
    logic              multi_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign hit_vec = found[p*TLBNUM +: TLBNUM];
    assign va_p    = va[p*32 +: 32];
    assign acc_p   = acc_type[p*2 +: 2];
    assign hit     = |hit_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi   = |(hit_vec & (hit_vec - ONE_T));

    // Lowest-index hit wins; scanning downward lets the last write be the lowest.
    always_comb begin
      idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (hit_vec[i]) idx = IDX_W'(i);
      end
    end

    always_comb begin
      big = (all_ps[int'(idx)*6 +: 6] == 6'd21);
      // The page-pair select bit sits just above the page offset.
      odd = big ? va_p[21] : va_p[12];
      if (odd) begin
        pfn = all_pfn1[int'(idx)*20 +: 20];
        mat = all_mat1[int'(idx)*2 +: 2];
        plv = all_plv1[int'(idx)*2 +: 2];
        d   = all_d1[idx];
        v   = all_v1[idx];
      end else begin
        pfn = all_pfn0[int'(idx)*20 +: 20];
        mat = all_mat0[int'(idx)*2 +: 2];
        plv = all_plv0[int'(idx)*2 +: 2];
        d   = all_d0[idx];
        v   = all_v0[idx];
      end
    end

    always_comb begin
      pa_d  = va_p;
      mat_d = 2'b00;
      exc_d = EXC_NONE;
      if (!hit) begin
        exc_d = EXC_TLBR;
      end else begin
        pa_d  = big ? {pfn[19:9], va_p[20:0]} : {pfn, va_p[11:0]};
        mat_d = mat;
        if (!v) begin
          if (acc_p == ACC_FETCH)      exc_d = EXC_PIF;
          else if (acc_p == ACC_STORE) exc_d = EXC_PIS;
          else                         exc_d = EXC_PIL;
        end else if (cur_plv > plv) begin
          exc_d = EXC_PPI;
        end else if ((acc_p == ACC_STORE) && !d) begin
          exc_d = EXC_PME;
        end
      end
    end

    assign in_ready[p] = !valid_q || out_ready[p];
    assign capture     = in_valid[p] && in_ready[p];

    always_comb begin
      valid_d = valid_q;
      if (flush)             valid_d = 1'b0;
      else if (capture)      valid_d = 1'b1;
      else if (out_ready[p]) valid_d = 1'b0;

      // Misses are counted even when flush discards the captured result.
      cnt_d = cnt_q;
      if (cnt_clr)                             cnt_d = '0;
      else if (capture && !hit && cnt_q != '1) cnt_d = cnt_q + ONE_C;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        pa_q    <= '0;
        mat_q   <= '0;
        exc_q   <= '0;
        multi_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        valid_q <= valid_d;
        cnt_q   <= cnt_d;
        if (capture && !flush) begin
          pa_q    <= pa_d;
          mat_q   <= mat_d;
          exc_q   <= exc_d;
          multi_q <= multi;
        end
      end
    end

    assign out_valid[p]             = valid_q;
    assign out_pa[p*32 +: 32]       = pa_q;
    assign out_mat[p*2 +: 2]        = mat_q;
    assign out_exc[p*3 +: 3]        = exc_q;
    assign out_multihit[p]          = multi_q;
    assign miss_cnt[p*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_tlb_lookup_stage.sv
module tb_tlb_lookup_stage;
  localparam int TLBNUM  = 16;
  localparam int NPORT   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic                    clk;
  logic                    rst;
  logic [TLBNUM*20-1:0]    all_pfn0, all_pfn1;
  logic [TLBNUM*2-1:0]     all_mat0, all_mat1, all_plv0, all_plv1;
  logic [TLBNUM-1:0]       all_d0, all_d1, all_v0, all_v1;
  logic [TLBNUM*6-1:0]     all_ps;
  logic [1:0]              cur_plv;
  logic [NPORT-1:0]        in_valid, in_ready, out_valid, out_ready, out_multihit;
  logic [NPORT*TLBNUM-1:0] found;
  logic [NPORT*32-1:0]     va, out_pa;
  logic [NPORT*2-1:0]      acc_type, out_mat;
  logic [NPORT*3-1:0]      out_exc;
  logic                    flush, cnt_clr;
  logic [NPORT*CNT_W-1:0]  miss_cnt;

  tlb_lookup_stage #(.TLBNUM(TLBNUM), .NPORT(NPORT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .all_pfn0(all_pfn0), .all_mat0(all_mat0), .all_plv0(all_plv0), .all_d0(all_d0), .all_v0(all_v0),
    .all_pfn1(all_pfn1), .all_mat1(all_mat1), .all_plv1(all_plv1), .all_d1(all_d1), .all_v1(all_v1),
    .all_ps(all_ps), .cur_plv(cur_plv),
    .in_valid(in_valid), .in_ready(in_ready), .found(found), .va(va), .acc_type(acc_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_pa(out_pa), .out_mat(out_mat),
    .out_exc(out_exc), .out_multihit(out_multihit),
    .flush(flush), .cnt_clr(cnt_clr), .miss_cnt(miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- TLB contents ----------------
  logic [19:0] e_pfn0[TLBNUM], e_pfn1[TLBNUM];
  logic [1:0]  e_mat0[TLBNUM], e_mat1[TLBNUM], e_plv0[TLBNUM], e_plv1[TLBNUM];
  logic        e_d0[TLBNUM], e_d1[TLBNUM], e_v0[TLBNUM], e_v1[TLBNUM];
  logic [5:0]  e_ps[TLBNUM];

  always_comb begin
    all_pfn0 = '0; all_pfn1 = '0; all_mat0 = '0; all_mat1 = '0;
    all_plv0 = '0; all_plv1 = '0; all_d0 = '0; all_d1 = '0;
    all_v0 = '0; all_v1 = '0; all_ps = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      all_pfn0[i*20 +: 20] = e_pfn0[i];
      all_pfn1[i*20 +: 20] = e_pfn1[i];
      all_mat0[i*2 +: 2]   = e_mat0[i];
      all_mat1[i*2 +: 2]   = e_mat1[i];
      all_plv0[i*2 +: 2]   = e_plv0[i];
      all_plv1[i*2 +: 2]   = e_plv1[i];
      all_d0[i] = e_d0[i]; all_d1[i] = e_d1[i];
      all_v0[i] = e_v0[i]; all_v1[i] = e_v1[i];
      all_ps[i*6 +: 6] = e_ps[i];
    end
  end

  task automatic set_entry(input int i, input logic [5:0] ps,
                           input logic [19:0] pfn0, input logic [1:0] mat0, input logic [1:0] plv0,
                           input logic d0, input logic v0,
                           input logic [19:0] pfn1, input logic [1:0] mat1, input logic [1:0] plv1,
                           input logic d1, input logic v1);
    e_ps[i] = ps;
    e_pfn0[i] = pfn0; e_mat0[i] = mat0; e_plv0[i] = plv0; e_d0[i] = d0; e_v0[i] = v0;
    e_pfn1[i] = pfn1; e_mat1[i] = mat1; e_plv1[i] = plv1; e_d1[i] = d1; e_v1[i] = v1;
  endtask

  task automatic setup_entries();
    for (int i = 0; i < TLBNUM; i++)
      set_entry(i, 6'd0, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    set_entry(0, 6'd12, 20'h00ABC, 2'd1, 2'd3, 1'b1, 1'b1, 20'h00DEF, 2'd0, 2'd0, 1'b1, 1'b1);
    set_entry(3, 6'd12, 20'h12345, 2'd1, 2'd3, 1'b1, 1'b1, 20'h54321, 2'd2, 2'd0, 1'b0, 1'b0);
    set_entry(5, 6'd21, 20'h0BEEF, 2'd2, 2'd0, 1'b0, 1'b1, 20'h00A00, 2'd1, 2'd3, 1'b0, 1'b1);
    set_entry(7, 6'd13, 20'h77777, 2'd3, 2'd3, 1'b1, 1'b1, 20'h11111, 2'd3, 2'd3, 1'b1, 1'b1);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        mh;
    logic [2:0]  exc;
    logic [1:0]  mat;
    logic [31:0] pa;
  } res_t;

  function automatic res_t model(input logic [15:0] f, input logic [31:0] a, input logic [1:0] t);
    res_t r;
    int e;
    longint page, off, frame;
    bit odd;
    logic [19:0] pfn;
    logic [1:0] mat, plv;
    logic v, dd;
    r.mh = ($countones(f) > 1);
    e = -1;
    for (int i = 0; i < TLBNUM; i++) if (f[i] && e < 0) e = i;
    if (e < 0) begin
      r.pa = a; r.mat = 2'd0; r.exc = 3'd1;
      return r;
    end
    page = (e_ps[e] == 6'd21) ? 64'd2097152 : 64'd4096;
    odd  = (((longint'(a) / page) % 2) == 1);
    pfn  = odd ? e_pfn1[e] : e_pfn0[e];
    mat  = odd ? e_mat1[e] : e_mat0[e];
    plv  = odd ? e_plv1[e] : e_plv0[e];
    v    = odd ? e_v1[e]   : e_v0[e];
    dd   = odd ? e_d1[e]   : e_d0[e];
    frame = (longint'(pfn) * 4096) / page * page;
    off   = longint'(a) % page;
    r.pa  = 32'(frame + off);
    r.mat = mat;
    if (!v)                         r.exc = (t == 2'd0) ? 3'd2 : ((t == 2'd2) ? 3'd4 : 3'd3);
    else if (int'(cur_plv) > int'(plv)) r.exc = 3'd6;
    else if (t == 2'd2 && !dd)      r.exc = 3'd5;
    else                            r.exc = 3'd0;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [37:0] exp_q0[$];
  logic [37:0] exp_q1[$];
  int exp_cnt[NPORT];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_res(input int p, input string tag, input res_t r);
    chk($sformatf("%s_p%0d_pa", tag, p),  out_pa[p*32 +: 32], r.pa);
    chk($sformatf("%s_p%0d_mat", tag, p), 32'(out_mat[p*2 +: 2]), 32'(r.mat));
    chk($sformatf("%s_p%0d_exc", tag, p), 32'(out_exc[p*3 +: 3]), 32'(r.exc));
    chk($sformatf("%s_p%0d_mh", tag, p),  32'(out_multihit[p]), 32'(r.mh));
  endtask

  // Inputs are set just after a negedge; this samples, updates the
  // scoreboard for the coming posedge, and returns at the next negedge.
  task automatic step();
    res_t r;
    int qs;
    #1;
    for (int p = 0; p < NPORT; p++) begin
      qs = (p == 0) ? exp_q0.size() : exp_q1.size();
      chk($sformatf("sb_p%0d_out_valid", p), 32'(out_valid[p]), 32'(qs > 0));
      chk($sformatf("sb_p%0d_in_ready", p), 32'(in_ready[p]), 32'((qs == 0) || out_ready[p]));
      chk($sformatf("sb_p%0d_miss_cnt", p), 32'(miss_cnt[p*CNT_W +: CNT_W]), 32'(exp_cnt[p]));
      if (out_valid[p] && out_ready[p] && qs > 0) begin
        if (p == 0) r = res_t'(exp_q0.pop_front());
        else        r = res_t'(exp_q1.pop_front());
        chk_res(p, "sb", r);
      end
      if (in_valid[p] && in_ready[p]) begin
        r = model(found[p*TLBNUM +: TLBNUM], va[p*32 +: 32], acc_type[p*2 +: 2]);
        if (p == 0) exp_q0.push_back(r);
        else        exp_q1.push_back(r);
        if (found[p*TLBNUM +: TLBNUM] == '0 && exp_cnt[p] < CNT_MAX) exp_cnt[p]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_port(input int p, input logic [15:0] f, input logic [31:0] a, input logic [1:0] t);
    found[p*TLBNUM +: TLBNUM] = f;
    va[p*32 +: 32]            = a;
    acc_type[p*2 +: 2]        = t;
  endtask

  task automatic rand_inputs();
    int m;
    for (int i = 0; i < TLBNUM; i++) begin
      m = $urandom_range(0, 3);
      e_ps[i] = (m == 0) ? 6'd12 : ((m == 3) ? 6'($urandom) : 6'd21);
      e_pfn0[i] = 20'($urandom); e_pfn1[i] = 20'($urandom);
      e_mat0[i] = 2'($urandom);  e_mat1[i] = 2'($urandom);
      e_plv0[i] = 2'($urandom);  e_plv1[i] = 2'($urandom);
      e_d0[i] = 1'($urandom); e_d1[i] = 1'($urandom);
      e_v0[i] = ($urandom_range(0, 3) != 0); e_v1[i] = ($urandom_range(0, 3) != 0);
    end
    cur_plv = 2'($urandom);
    for (int p = 0; p < NPORT; p++) begin
      in_valid[p]  = ($urandom_range(0, 3) != 0);
      out_ready[p] = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 7);
      if (m == 0)      found[p*TLBNUM +: TLBNUM] = '0;
      else if (m == 1) found[p*TLBNUM +: TLBNUM] = 16'($urandom);
      else             found[p*TLBNUM +: TLBNUM] = 16'(1) << $urandom_range(0, 15);
      va[p*32 +: 32]     = 32'($urandom);
      acc_type[p*2 +: 2] = 2'($urandom);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          port;
    logic [15:0] found;
    logic [31:0] va;
    logic [1:0]  acc;
    logic [1:0]  cplv;
    logic [31:0] pa;
    logic [1:0]  mat;
    logic [2:0]  exc;
    logic        mh;
  } vec_t;

  vec_t vecs[12];

  initial begin
    res_t r;
    int p;

    vecs[0]  = '{0, 16'h0008, 32'h00002ABC, 2'd0, 2'd3, 32'h12345ABC, 2'd1, 3'd0, 1'b0};
    vecs[1]  = '{1, 16'h0020, 32'h00601234, 2'd2, 2'd0, 32'h00A01234, 2'd1, 3'd5, 1'b0};
    vecs[2]  = '{0, 16'h0000, 32'h12345678, 2'd1, 2'd3, 32'h12345678, 2'd0, 3'd1, 1'b0};
    vecs[3]  = '{0, 16'h0008, 32'h00003000, 2'd0, 2'd3, 32'h54321000, 2'd2, 3'd2, 1'b0};
    vecs[4]  = '{1, 16'h0008, 32'h00001000, 2'd2, 2'd0, 32'h54321000, 2'd2, 3'd4, 1'b0};
    vecs[5]  = '{1, 16'h0008, 32'h00001000, 2'd3, 2'd0, 32'h54321000, 2'd2, 3'd3, 1'b0};
    vecs[6]  = '{0, 16'h0001, 32'h00001FFF, 2'd1, 2'd3, 32'h00DEFFFF, 2'd0, 3'd6, 1'b0};
    vecs[7]  = '{1, 16'h0021, 32'h00000123, 2'd1, 2'd0, 32'h00ABC123, 2'd1, 3'd0, 1'b1};
    vecs[8]  = '{0, 16'h0080, 32'h00201ABC, 2'd2, 2'd3, 32'h11111ABC, 2'd3, 3'd0, 1'b0};
    vecs[9]  = '{1, 16'h0020, 32'h00012345, 2'd1, 2'd0, 32'h0BE12345, 2'd2, 3'd0, 1'b0};
    vecs[10] = '{0, 16'h0020, 32'h00012345, 2'd2, 2'd1, 32'h0BE12345, 2'd2, 3'd6, 1'b0};
    vecs[11] = '{0, 16'h0020, 32'h00012345, 2'd2, 2'd0, 32'h0BE12345, 2'd2, 3'd5, 1'b0};

    setup_entries();
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; cur_plv = 2'd0;
    in_valid = '0; out_ready = '1; found = '0; va = '0; acc_type = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h3);
    chk("rst_out_pa", out_pa[31:0], 32'h0);
    chk("rst_out_pa1", out_pa[63:32], 32'h0);
    chk("rst_out_exc", 32'(out_exc), 32'h0);
    chk("rst_out_mat", 32'(out_mat), 32'h0);
    chk("rst_multihit", 32'(out_multihit), 32'h0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);

    // table-driven directed vectors, one request at a time, latency 1
    for (int i = 0; i < 12; i++) begin
      p = vecs[i].port;
      cur_plv = vecs[i].cplv;
      drive_port(p, vecs[i].found, vecs[i].va, vecs[i].acc);
      in_valid = '0;
      in_valid[p] = 1'b1;
      @(negedge clk);
      in_valid = '0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid[p]), 32'h1);
      r.pa = vecs[i].pa; r.mat = vecs[i].mat; r.exc = vecs[i].exc; r.mh = vecs[i].mh;
      chk_res(p, $sformatf("vec%0d", i), r);
      if (vecs[i].found == '0) exp_cnt[p]++;
    end
    chk("table_miss_cnt0", 32'(miss_cnt[0 +: CNT_W]), 32'd1);
    chk("table_miss_cnt1", 32'(miss_cnt[CNT_W +: CNT_W]), 32'd0);

    // flush with a held result; the miss captured during flush still counts
    cur_plv = 2'd3;
    drive_port(0, 16'h0008, 32'h00002ABC, 2'd0);
    in_valid = 2'b01;
    @(negedge clk);
    chk("flush_pre_valid", 32'(out_valid[0]), 32'h1);
    drive_port(0, 16'h0000, 32'h0BAD0000, 2'd1);
    flush = 1'b1;
    exp_cnt[0]++;
    @(negedge clk);
    flush = 1'b0;
    in_valid = '0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_miss_cnt0", 32'(miss_cnt[0 +: CNT_W]), 32'(exp_cnt[0]));

    // clear beats a simultaneous miss on both ports
    drive_port(0, 16'h0000, 32'hCAFE0000, 2'd1);
    drive_port(1, 16'h0000, 32'hCAFE1111, 2'd2);
    in_valid = 2'b11;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    in_valid = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    chk("clr_miss_cnt", 32'(miss_cnt), 32'h0);
    chk("clr_valid", 32'(out_valid), 32'h3);
    chk("clr_exc0", 32'(out_exc[2:0]), 32'd1);
    chk("clr_pa0", out_pa[31:0], 32'hCAFE0000);
    chk("clr_pa1", out_pa[63:32], 32'hCAFE1111);
    @(negedge clk);

    // saturation: stream misses on port 0 past the counter's maximum
    drive_port(0, 16'h0000, 32'h00000000, 2'd1);
    in_valid = 2'b01; out_ready = '1;
    for (int k = 0; k < 260; k++) begin
      va[31:0] = 32'($urandom);
      step();
    end
    in_valid = '0;
    step();
    chk("sat_miss_cnt0", 32'(miss_cnt[0 +: CNT_W]), 32'hFF);
    chk("sat_miss_cnt1", 32'(miss_cnt[CNT_W +: CNT_W]), 32'h0);
    step();

    // back-pressure on port 0 while port 1 streams misses
    setup_entries();
    cur_plv = 2'd3;
    drive_port(0, 16'h0008, 32'h00002ABC, 2'd0);
    drive_port(1, 16'h0000, 32'($urandom), 2'd1);
    in_valid = 2'b11; out_ready = 2'b10;
    step();
    drive_port(0, 16'h0001, 32'h00000123, 2'd1);
    for (int k = 0; k < 3; k++) begin
      va[63:32] = 32'($urandom);
      #1;
      chk($sformatf("bp%0d_in_ready0", k), 32'(in_ready[0]), 32'h0);
      chk($sformatf("bp%0d_pa0_hold", k), out_pa[31:0], 32'h12345ABC);
      step();
    end
    out_ready = 2'b11;
    va[63:32] = 32'($urandom);
    step();
    in_valid = 2'b10;
    va[63:32] = 32'($urandom);
    #1;
    chk("bp_next_valid0", 32'(out_valid[0]), 32'h1);
    chk("bp_next_pa0", out_pa[31:0], 32'h00ABC123);
    step();
    in_valid = '0;
    step();
    step();

    // randomized traffic against the reference model
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int k = 0; k < 600; k++) begin
      rand_inputs();
      step();
    end
    in_valid = '0; out_ready = '1;
    step();
    step();
    chk("drain_q0", 32'(exp_q0.size()), 32'h0);
    chk("drain_q1", 32'(exp_q1.size()), 32'h0);

    // reset in the middle of a capture drops it without an out_valid pulse
    setup_entries();
    drive_port(0, 16'h0008, 32'h00002ABC, 2'd0);
    drive_port(1, 16'h0000, 32'h0000FFFF, 2'd1);
    in_valid = 2'b11; out_ready = '1;
    rst = 1'b1;
    @(negedge clk);
    in_valid = '0;
    chk("rstmid_valid", 32'(out_valid), 32'h0);
    chk("rstmid_miss_cnt", 32'(miss_cnt), 32'h0);
    chk("rstmid_in_ready", 32'(in_ready), 32'h3);
    chk("rstmid_pa0", out_pa[31:0], 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
